// File: rtl/led_pattern_gen.sv
// Multi-channel LED driver: per-channel OFF/ON/BLINK/PWM modes, shared prescaler
// tick for blink timing and a shared free-running PWM counter.
module led_pattern_gen #(
  parameter int CLK_HZ      = 12000000,
  parameter int TICK_HZ     = 1000,
  parameter int CHANNELS    = 5,
  parameter int PERIOD_BITS = 12,
  parameter int PWM_BITS    = 8,
  localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_we,
  input  logic [CH_W-1:0]        cfg_ch,
  input  logic [1:0]             cfg_mode,
  input  logic [PERIOD_BITS-1:0] cfg_value,
  output logic [CHANNELS-1:0]    led,
  output logic                   tick
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
  localparam logic [CH_W:0]    CH_LIMIT = (CH_W + 1)'(CHANNELS);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PWM   = 2'd3
  } mode_e;

  logic [PRE_W-1:0]    pre_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                tick_stb;
  logic                cfg_valid;
  logic [CHANNELS-1:0] led_next;

  // Blink counters advance on the same edge that raises the registered tick.
  assign tick_stb  = (pre_cnt == PRE_LAST);
  assign cfg_valid = cfg_we && ({1'b0, cfg_ch} < CH_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
      tick    <= 1'b0;
      led     <= '0;
    end else begin
      pre_cnt <= tick_stb ? '0 : pre_cnt + PRE_W'(1);
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      tick    <= tick_stb;
      led     <= led_next;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    mode_e                  mode;
    logic [PERIOD_BITS-1:0] value;
    logic [PERIOD_BITS-1:0] blink_cnt;
    logic [PERIOD_BITS-1:0] half_last;
    logic                   phase;
    logic                   sel;
    logic                   drive;

    assign sel       = cfg_valid && (cfg_ch == CH_W'(g));
    // A half-period of 0 behaves as 1 tick.
    assign half_last = (value == '0) ? '0 : value - PERIOD_BITS'(1);

    // A write to this channel takes priority over a coincident tick.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mode      <= MODE_OFF;
        value     <= '0;
        blink_cnt <= '0;
        phase     <= 1'b0;
      end else if (sel) begin
        mode      <= mode_e'(cfg_mode);
        value     <= cfg_value;
        blink_cnt <= '0;
        phase     <= 1'b0;
      end else if (tick_stb && (mode == MODE_BLINK)) begin
        if (blink_cnt == half_last) begin
          blink_cnt <= '0;
          phase     <= ~phase;
        end else begin
          blink_cnt <= blink_cnt + PERIOD_BITS'(1);
        end
      end
    end

    always_comb begin
      drive = 1'b0;
      case (mode)
        MODE_OFF:   drive = 1'b0;
        MODE_ON:    drive = 1'b1;
        MODE_BLINK: drive = phase;
        MODE_PWM:   drive = (pwm_cnt < value[PWM_BITS-1:0]);
      endcase
    end

    assign led_next[g] = drive;
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen (DIV=10, 5 channels, 8-bit PWM):
// vector table for steady-state behaviour plus timed sequences for corner cases.
module tb_led_pattern_gen;

  localparam logic [1:0] M_OFF   = 2'd0;
  localparam logic [1:0] M_ON    = 2'd1;
  localparam logic [1:0] M_BLINK = 2'd2;
  localparam logic [1:0] M_PWM   = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we;
  logic [2:0]  cfg_ch;
  logic [1:0]  cfg_mode;
  logic [11:0] cfg_value;
  logic [4:0]  led;
  logic        tick;

  led_pattern_gen #(
    .CLK_HZ(100),
    .TICK_HZ(10),
    .CHANNELS(5),
    .PERIOD_BITS(12),
    .PWM_BITS(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cfg_we(cfg_we),
    .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode),
    .cfg_value(cfg_value),
    .led(led),
    .tick(tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int unsigned exp;
  } exp_t;

  typedef struct {
    logic [2:0]  ch;
    logic [1:0]  mode;
    logic [11:0] value;
    int unsigned win;
    int unsigned exp_high;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[9];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic push(input string n, input int unsigned e);
    exp_t x;
    x.name = n;
    x.exp  = e;
    sb.push_back(x);
  endtask

  task automatic check(input int unsigned act);
    exp_t x;
    n_checks++;
    if (sb.size() == 0) begin
      $display("FAIL scoreboard_empty: got %0d, nothing expected", act);
      return;
    end
    x = sb.pop_front();
    if (act == x.exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", x.name, act, x.exp);
  endtask

  task automatic expect_eq(input string n, input int unsigned e, input int unsigned a);
    push(n, e);
    check(a);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] ch, input logic [1:0] mode, input logic [11:0] value);
    cfg_we    = 1'b1;
    cfg_ch    = ch;
    cfg_mode  = mode;
    cfg_value = value;
  endtask

  task automatic wr(input logic [2:0] ch, input logic [1:0] mode, input logic [11:0] value);
    drive(ch, mode, value);
    step();
    cfg_we = 1'b0;
  endtask

  // Returns just after the edge that raised tick (a prescaler strobe edge).
  task automatic sync_tick();
    int unsigned n = 0;
    do begin
      step();
      n++;
    end while (tick !== 1'b1 && n < 20);
    expect_eq("sync_tick", 1, (tick === 1'b1) ? 1 : 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned bad;
    int unsigned highs;
    int unsigned others;
    int unsigned e;

    vecs[0] = '{3'd4, M_PWM,   12'd0,     256, 0};
    vecs[1] = '{3'd4, M_PWM,   12'd64,    256, 64};
    vecs[2] = '{3'd4, M_PWM,   12'd255,   256, 255};
    vecs[3] = '{3'd4, M_PWM,   12'd128,   256, 128};
    vecs[4] = '{3'd4, M_PWM,   12'hF01,   256, 1};
    vecs[5] = '{3'd3, M_ON,    12'd0,     50,  50};
    vecs[6] = '{3'd1, M_OFF,   12'd7,     30,  0};
    vecs[7] = '{3'd0, M_BLINK, 12'd1,     40,  20};
    vecs[8] = '{3'd2, M_BLINK, 12'd2,     80,  40};

    rst_n = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_mode = '0; cfg_value = '0;

    // Reset and tick cadence
    bad = 0;
    repeat (3) begin
      step();
      if (led !== 5'd0 || tick !== 1'b0) bad++;
    end
    expect_eq("reset_idle", 0, bad);
    #3 rst_n = 1'b1;
    bad = 0;
    for (int k = 1; k <= 40; k++) begin
      push($sformatf("tick_edge%0d", k), (k % 10 == 0) ? 1 : 0);
      step();
      check((tick === 1'b1) ? 1 : 0);
      if (led !== 5'd0) bad++;
    end
    expect_eq("led_idle_after_reset", 0, bad);

    // Vector table: high count of target LED over a window, others stay dark
    for (int i = 0; i < 9; i++) begin
      wr(vecs[i].ch, vecs[i].mode, vecs[i].value);
      push($sformatf("vec%0d_high_count", i), vecs[i].exp_high);
      push($sformatf("vec%0d_other_leds", i), 0);
      highs = 0;
      others = 0;
      for (int unsigned w = 0; w < vecs[i].win; w++) begin
        step();
        if (led[vecs[i].ch] === 1'b1) highs++;
        if ((led & ~(5'd1 << vecs[i].ch)) !== 5'd0) others++;
      end
      check(highs);
      check(others);
      wr(vecs[i].ch, M_OFF, 12'd0);
    end
    step();

    // ON/OFF latency on ch2
    wr(3'd2, M_ON, 12'd0);
    expect_eq("on_write_edge", 0, led);
    step();
    expect_eq("on_next_edge", 5'b00100, led);
    repeat (4) step();
    expect_eq("on_hold", 5'b00100, led);
    wr(3'd2, M_OFF, 12'd0);
    expect_eq("off_write_edge", 5'b00100, led);
    step();
    expect_eq("off_next_edge", 0, led);

    // Blink H=3 with unrelated ch1 writes, including one on a tick edge
    sync_tick();
    for (int k = 1; k <= 130; k++) begin
      case (k)
        1:  drive(3'd0, M_BLINK, 12'd3);
        5:  drive(3'd1, M_ON,    12'd0);
        15: drive(3'd1, M_BLINK, 12'd5);
        20: drive(3'd1, M_PWM,   12'd100);
        40: drive(3'd1, M_OFF,   12'd0);
        default: ;
      endcase
      e = (k >= 31 && ((k - 31) / 30) % 2 == 0) ? 1 : 0;
      if (k >= 2) push($sformatf("blink3_k%0d", k), e);
      step();
      cfg_we = 1'b0;
      if (k >= 2) check(led[0]);
    end

    // Blink value 0 behaves as H=1
    sync_tick();
    for (int k = 1; k <= 40; k++) begin
      if (k == 1) drive(3'd0, M_BLINK, 12'd0);
      e = (((k - 1) / 10) % 2 == 1) ? 1 : 0;
      if (k >= 2) push($sformatf("blink0_k%0d", k), e);
      step();
      cfg_we = 1'b0;
      if (k >= 2) check(led[0]);
    end

    // Write coincident with a tick, then an out-of-range write, with ch2 ON
    wr(3'd2, M_ON, 12'd0);
    sync_tick();
    for (int k = 1; k <= 80; k++) begin
      if (k == 10) drive(3'd0, M_BLINK, 12'd2);
      if (k == 35) drive(3'd7, M_OFF, 12'd0);
      e = 5'b00100 | ((k >= 31 && ((k - 31) / 20) % 2 == 0) ? 1 : 0);
      if (k >= 11) push($sformatf("collide_k%0d", k), e);
      step();
      cfg_we = 1'b0;
      if (k >= 11) check(led);
    end

    // Asynchronous reset while ch0 is high and tick is asserted
    #3 rst_n = 1'b0;
    #1;
    expect_eq("async_reset_led", 0, led);
    expect_eq("async_reset_tick", 0, tick);
    repeat (2) step();
    #3 rst_n = 1'b1;
    bad = 0;
    repeat (40) begin
      step();
      if (led !== 5'd0) bad++;
    end
    expect_eq("off_after_reset", 0, bad);
    wr(3'd0, M_ON, 12'd0);
    step();
    expect_eq("rewrite_after_reset", 5'b00001, led);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
